// File: rtl/verin_pwm_gen_if.sv
// verin_pwm_gen_if: register-side inputs and bridge-side outputs of the tiller actuator
// PWM stage. The master drives the registers; the slave is the PWM generator.
interface verin_pwm_gen_if #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ANGLE_W = 12
) ();
    logic [CNT_W-1:0]   frequency;
    logic [CNT_W-1:0]   duty;
    logic               sens;
    logic [ANGLE_W-1:0] angle_barre;
    logic [ANGLE_W-1:0] butee_d;
    logic [ANGLE_W-1:0] butee_g;
    logic               pwm_out;
    logic               sens_out;
    logic               fin_course_d;
    logic               fin_course_g;
    logic               period_tick;

    modport master (
        output frequency, duty, sens, angle_barre, butee_d, butee_g,
        input  pwm_out, sens_out, fin_course_d, fin_course_g, period_tick
    );

    modport slave (
        input  frequency, duty, sens, angle_barre, butee_d, butee_g,
        output pwm_out, sens_out, fin_course_d, fin_course_g, period_tick
    );
endinterface

// File: rtl/verin_pwm_gen.sv
// verin_pwm_gen: H-bridge PWM with shadowed period/duty/direction and hardware
// end-of-travel cut-off. Define VERIN_DEAD_TIME_EN to add dead time on reversal.
module verin_pwm_gen #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ANGLE_W     = 12,
    parameter int unsigned DEAD_CYCLES = 50
) (
    input logic            clk_clk,
    input logic            reset_reset,
    verin_pwm_gen_if.slave bus
);

`ifdef VERIN_DEAD_TIME_EN
    typedef enum logic [1:0] {StIdle, StRun, StBlocked, StDead} state_e;
    localparam logic [CNT_W-1:0] DeadLast = CNT_W'(DEAD_CYCLES - 1);
`else
    typedef enum logic [1:0] {StIdle, StRun, StBlocked} state_e;
`endif

    if (DEAD_CYCLES == 0) begin : gen_dead_check
        $error("DEAD_CYCLES must be at least 1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic               sens_q, sens_d;
    logic               fin_d_q, fin_g_q;
    logic               pwm_q, pwm_d;
    logic               sens_out_q, sens_out_d;
    logic               tick_q, tick_d;
    logic               boundary;
    logic [ANGLE_W-1:0] angle, lim_d, lim_g;

    assign angle = bus.angle_barre;
    assign lim_d = bus.butee_d;
    assign lim_g = bus.butee_g;

    logic at_end, freq_ok, blocked, blocked_new;
    assign at_end      = (cnt_q == period_q - CNT_W'(1));
    assign freq_ok     = (bus.frequency >= CNT_W'(2));
    assign blocked     = sens_q ? fin_d_q : fin_g_q;
    // Blocking as it will be once the direction sampled at this boundary is active.
    assign blocked_new = bus.sens ? fin_d_q : fin_g_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        duty_d   = duty_q;
        sens_d   = sens_q;
        boundary = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                period_d = bus.frequency;
                duty_d   = bus.duty;
                sens_d   = bus.sens;
                if (freq_ok) state_d = StRun;
            end
            StRun, StBlocked: begin
                if (state_q == StRun && blocked) state_d = StBlocked;
                if (at_end) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    period_d = bus.frequency;
                    duty_d   = bus.duty;
                    sens_d   = bus.sens;
                    if (!freq_ok) state_d = StIdle;
`ifdef VERIN_DEAD_TIME_EN
                    else if (bus.sens != sens_q) state_d = StDead;
`endif
                    else state_d = blocked_new ? StBlocked : StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef VERIN_DEAD_TIME_EN
            StDead: begin
                if (cnt_q == DeadLast) begin
                    cnt_d   = '0;
                    state_d = blocked ? StBlocked : StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pwm_d  = (state_q == StRun) && !blocked && (cnt_q < duty_q);
        tick_d = boundary && (state_d == StRun || state_d == StBlocked);
`ifdef VERIN_DEAD_TIME_EN
        // The bridge keeps its old direction until the dead time has elapsed.
        sens_out_d = (state_d == StDead) ? sens_out_q : sens_d;
`else
        sens_out_d = sens_d;
`endif
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt_q      <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            sens_q     <= 1'b0;
            fin_d_q    <= 1'b0;
            fin_g_q    <= 1'b0;
            pwm_q      <= 1'b0;
            sens_out_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            sens_q     <= sens_d;
            fin_d_q    <= (angle >= lim_d);
            fin_g_q    <= (angle <= lim_g);
            pwm_q      <= pwm_d;
            sens_out_q <= sens_out_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.sens_out     = sens_out_q;
    assign bus.fin_course_d = fin_d_q;
    assign bus.fin_course_g = fin_g_q;
    assign bus.period_tick  = tick_q;

endmodule
